// File: rtl/uart_hd_tx_arbiter_if.sv
// Requester and UART-TX side signals of the half-duplex TX arbiter.
// Handshake: i_Req[n] is a level valid held until the one-cycle o_Ack[n] retires it; o_Tx_DV is a one-cycle strobe with no back-pressure, closed by i_Tx_Done.
interface uart_hd_tx_arbiter_if;
  logic [1:0] i_Req;
  logic [7:0] i_Req_Byte0;
  logic [7:0] i_Req_Byte1;
  logic [1:0] o_Ack;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done;

  modport slave (
    input  i_Req, i_Req_Byte0, i_Req_Byte1, i_Tx_Active, i_Tx_Done,
    output o_Ack, o_Tx_DV, o_Tx_Byte
  );

  modport master (
    output i_Req, i_Req_Byte0, i_Req_Byte1, i_Tx_Active, i_Tx_Done,
    input  o_Ack, o_Tx_DV, o_Tx_Byte
  );
endinterface

// File: rtl/uart_hd_tx_arbiter.sv
// Half-duplex line arbiter: waits for a quiet RX line, grants one of two requesters round-robin and frames the TX with driver-enable guard times.
// Optional macro UART_HD_TIMEOUT_EN adds an S_WAIT watchdog and the o_Tx_Err pulse.
module uart_hd_tx_arbiter #(
  parameter int CLKS_PER_BIT = 87,
  parameter int QUIET_BITS   = 2,
  parameter int LEAD_CLKS    = 4,
  parameter int TAIL_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  uart_hd_tx_arbiter_if.slave  bus,
  output logic                 o_Tx_En,
  output logic                 o_Line_Busy,
`ifdef UART_HD_TIMEOUT_EN
  output logic                 o_Tx_Err,
`endif
  output logic [3:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEAD = 3'd1,
    S_LOAD = 3'd2,
    S_WAIT = 3'd3,
    S_TAIL = 3'd4
  } state_t;

  localparam logic [15:0] QUIET_MAX = 16'(QUIET_BITS * CLKS_PER_BIT);
  localparam logic [15:0] LEAD_LAST = 16'(LEAD_CLKS - 1);
  localparam logic [15:0] TAIL_LAST = 16'(TAIL_BITS * CLKS_PER_BIT - 1);
`ifdef UART_HD_TIMEOUT_EN
  localparam logic [15:0] WD_LAST   = 16'(12 * CLKS_PER_BIT - 1);
`endif

  state_t      state;
  logic        rx_meta;
  logic        rx_sync;
  logic [15:0] quiet_cnt;
  logic [15:0] quiet_nxt;
  logic [15:0] tmr;
  logic        ptr;
  logic        winner;
  logic        pick;
  logic [7:0]  win_byte;
  logic        tx_en;
  logic        line_busy;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [1:0]  ack;
`ifdef UART_HD_TIMEOUT_EN
  logic        tx_err;
`endif

  // Our own echo is not traffic, so the window is held at zero while we drive.
  always_comb begin
    quiet_nxt = quiet_cnt;
    if (tx_en || !rx_sync)
      quiet_nxt = '0;
    else if (quiet_cnt < QUIET_MAX)
      quiet_nxt = quiet_cnt + 16'd1;
  end

  always_comb begin
    pick = bus.i_Req[1];
    if (bus.i_Req == 2'b11)
      pick = ptr;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state     <= S_IDLE;
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      quiet_cnt <= '0;
      line_busy <= 1'b1;
      tmr       <= '0;
      ptr       <= 1'b0;
      winner    <= 1'b0;
      win_byte  <= '0;
      tx_en     <= 1'b0;
      tx_dv     <= 1'b0;
      tx_byte   <= '0;
      ack       <= '0;
`ifdef UART_HD_TIMEOUT_EN
      tx_err    <= 1'b0;
`endif
    end else begin
      rx_meta   <= i_Rx_Serial;
      rx_sync   <= rx_meta;
      quiet_cnt <= quiet_nxt;
      line_busy <= (quiet_nxt < QUIET_MAX);
      tx_dv     <= 1'b0;
      ack       <= '0;
`ifdef UART_HD_TIMEOUT_EN
      tx_err    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          // Registered line_busy decides, so an RX edge this cycle cannot veto the grant.
          if ((|bus.i_Req) && !line_busy) begin
            winner   <= pick;
            win_byte <= pick ? bus.i_Req_Byte1 : bus.i_Req_Byte0;
            ptr      <= ~pick;
            tx_en    <= 1'b1;
            tmr      <= '0;
            state    <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (tmr == LEAD_LAST)
            state <= S_LOAD;
          else
            tmr <= tmr + 16'd1;
        end
        S_LOAD: begin
          tx_dv   <= 1'b1;
          tx_byte <= win_byte;
          ack     <= winner ? 2'b10 : 2'b01;
          tmr     <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.i_Tx_Done) begin
            tmr   <= '0;
            state <= S_TAIL;
          end
`ifdef UART_HD_TIMEOUT_EN
          else if (tmr == WD_LAST) begin
            tx_err <= 1'b1;
            tmr    <= '0;
            state  <= S_TAIL;
          end else begin
            tmr <= tmr + 16'd1;
          end
`endif
        end
        S_TAIL: begin
          if (tmr == TAIL_LAST) begin
            tx_en <= 1'b0;
            state <= S_IDLE;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        default: begin
          tx_en <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_Ack     = ack;
  assign bus.o_Tx_DV   = tx_dv;
  assign bus.o_Tx_Byte = tx_byte;
  assign o_Tx_En       = tx_en;
  assign o_Line_Busy   = line_busy;
`ifdef UART_HD_TIMEOUT_EN
  assign o_Tx_Err      = tx_err;
`endif
  // Bit 3 mirrors the transmitter busy flag, which the sequencing itself never needs.
  assign dbg_state     = {bus.i_Tx_Active, state};

endmodule

// File: tb/tb_uart_hd_tx_arbiter.sv
// Directed bench for uart_hd_tx_arbiter at CLKS_PER_BIT=8; expected {ack, byte} pairs queue up as requests are raised.
module tb_uart_hd_tx_arbiter;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       tx_en;
  logic       line_busy;
  logic [3:0] dbg_state;
`ifdef UART_HD_TIMEOUT_EN
  logic       tx_err;
`endif

  uart_hd_tx_arbiter_if bus();

  logic [9:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_hd_tx_arbiter #(
    .CLKS_PER_BIT(CPB),
    .QUIET_BITS(2),
    .LEAD_CLKS(4),
    .TAIL_BITS(1)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .i_Rx_Serial(rx),
    .bus(bus),
    .o_Tx_En(tx_en),
    .o_Line_Busy(line_busy),
`ifdef UART_HD_TIMEOUT_EN
    .o_Tx_Err(tx_err),
`endif
    .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic wait_en(input logic lvl, input int budget, output int n);
    n = 0;
    while (tx_en !== lvl && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Called with tx_en just risen: load strobe is 5 clocks after the grant.
  task automatic expect_load(input string tag);
    int n;
    logic [9:0] e;
    n = 0;
    while (bus.o_Tx_DV !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, "dv_latency", n, 5);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
    check(tag, "ack", {30'd0, bus.o_Ack}, {30'd0, e[9:8]});
    check(tag, "byte", {24'd0, bus.o_Tx_Byte}, {24'd0, e[7:0]});
    tick();
    check(tag, "ack_pulse", {30'd0, bus.o_Ack}, 0);
    check(tag, "dv_pulse", {31'd0, bus.o_Tx_DV}, 0);
  endtask

  task automatic tx_finish(input string tag);
    int n;
    bus.i_Tx_Active = 1'b1;
    repeat (3) tick();
    bus.i_Tx_Done = 1'b1;
    tick();
    bus.i_Tx_Done   = 1'b0;
    bus.i_Tx_Active = 1'b0;
    check(tag, "en_in_tail", {31'd0, tx_en}, 1);
    wait_en(1'b0, 40, n);
    check(tag, "tail_clks", n, 8);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    rx  = 1'b1;
    bus.i_Req       = 2'b00;
    bus.i_Req_Byte0 = 8'h00;
    bus.i_Req_Byte1 = 8'h00;
    bus.i_Tx_Active = 1'b0;
    bus.i_Tx_Done   = 1'b0;

    // Reset values
    repeat (3) tick();
    check("reset", "tx_en", {31'd0, tx_en}, 0);
    check("reset", "busy", {31'd0, line_busy}, 1);
    check("reset", "dv", {31'd0, bus.o_Tx_DV}, 0);
    check("reset", "ack", {30'd0, bus.o_Ack}, 0);
    check("reset", "byte", {24'd0, bus.o_Tx_Byte}, 0);
    check("reset", "state", {29'd0, dbg_state[2:0]}, 0);
    rst = 1'b0;

    // Single request after 20 idle clocks
    repeat (20) tick();
    check("t1", "quiet", {31'd0, line_busy}, 0);
    bus.i_Req = 2'b01;
    bus.i_Req_Byte0 = 8'hA5;
    exp_q.push_back({2'b01, 8'hA5});
    tick();
    check("t1", "grant", {31'd0, tx_en}, 1);
    expect_load("t1");
    bus.i_Req = 2'b00;
    tx_finish("t1");

    // Both requesters held: strict alternation starting from requester 0
    do_reset();
    bus.i_Req = 2'b11;
    bus.i_Req_Byte0 = 8'h11;
    bus.i_Req_Byte1 = 8'h22;
    exp_q.push_back({2'b01, 8'h11});
    exp_q.push_back({2'b10, 8'h22});
    exp_q.push_back({2'b01, 8'h11});
    exp_q.push_back({2'b10, 8'h22});
    for (int i = 0; i < 4; i++) begin
      wait_en(1'b1, 60, n);
      // Enable low for 16 counted quiet clocks plus the registered busy flag.
      if (i == 0) check("t2", "grant", {31'd0, tx_en}, 1);
      else        check("t2", "gap", n, 17);
      expect_load("t2");
      if (i == 3) bus.i_Req = 2'b00;
      tx_finish("t2");
    end

    // RX traffic keeps the line busy; release then grant
    bus.i_Req = 2'b01;
    bus.i_Req_Byte0 = 8'h3C;
    exp_q.push_back({2'b01, 8'h3C});
    for (int p = 0; p < 5; p++) begin
      rx = 1'b0;
      tick();
      rx = 1'b1;
      for (int k = 0; k < 9; k++) begin
        tick();
        check("t3", "busy", {31'd0, line_busy}, 1);
        check("t3", "no_en", {31'd0, tx_en}, 0);
      end
    end
    rx = 1'b0;
    tick();
    rx = 1'b1;
    // 2 sync flops, 16 quiet counts, 1 registered busy flag.
    wait_en(1'b1, 60, n);
    check("t3", "release", n, 19);
    expect_load("t3");
    bus.i_Req = 2'b00;
    tx_finish("t3");

    // Reset during S_WAIT, pointer returns to requester 0
    bus.i_Req = 2'b01;
    bus.i_Req_Byte0 = 8'h55;
    exp_q.push_back({2'b01, 8'h55});
    wait_en(1'b1, 60, n);
    check("t4", "grant", {31'd0, tx_en}, 1);
    expect_load("t4");
    bus.i_Tx_Active = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("t4", "en_drop", {31'd0, tx_en}, 0);
    check("t4", "ack", {30'd0, bus.o_Ack}, 0);
    check("t4", "dv", {31'd0, bus.o_Tx_DV}, 0);
    check("t4", "state", {29'd0, dbg_state[2:0]}, 0);
    check("t4", "busy", {31'd0, line_busy}, 1);
    rst = 1'b0;
    bus.i_Tx_Active = 1'b0;
    bus.i_Req = 2'b11;
    bus.i_Req_Byte0 = 8'h77;
    bus.i_Req_Byte1 = 8'h66;
    exp_q.push_back({2'b01, 8'h77});
    wait_en(1'b1, 60, n);
    check("t4", "regrant", {31'd0, tx_en}, 1);
    expect_load("t4");
    bus.i_Req = 2'b00;
    tx_finish("t4");

    // Request dropped during S_LEAD: latched byte still sent, one ack
    bus.i_Req = 2'b01;
    bus.i_Req_Byte0 = 8'h9A;
    exp_q.push_back({2'b01, 8'h9A});
    wait_en(1'b1, 60, n);
    check("t5", "grant", {31'd0, tx_en}, 1);
    bus.i_Req = 2'b00;
    bus.i_Req_Byte0 = 8'hFF;
    expect_load("t5");
    tx_finish("t5");
    repeat (30) tick();
    check("t5", "no_regrant", {31'd0, tx_en}, 0);
    check("t5", "no_ack", {30'd0, bus.o_Ack}, 0);

`ifdef UART_HD_TIMEOUT_EN
    // No done pulse: watchdog fires 96 clocks into S_WAIT
    bus.i_Req = 2'b01;
    bus.i_Req_Byte0 = 8'hE7;
    exp_q.push_back({2'b01, 8'hE7});
    wait_en(1'b1, 60, n);
    check("t6", "grant", {31'd0, tx_en}, 1);
    expect_load("t6");
    bus.i_Req = 2'b00;
    n = 0;
    while (tx_err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    // expect_load already consumed one S_WAIT clock.
    check("t6", "wd_clks", n, 95);
    tick();
    check("t6", "err_pulse", {31'd0, tx_err}, 0);
    wait_en(1'b0, 40, n);
    check("t6", "tail_clks", n, 7);
`endif

    check("end", "queue_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
